// File: rtl/gen_gamma_decoder.sv
// rtl/gen_gamma_decoder.sv - gamma (keystream) decoder with sequence-number sync check
// Regenerates the coder's LFSR gamma and recovers id = md - gamma per accepted word.
module gen_gamma_decoder #(
   parameter int SIZE = 8,
   parameter logic [SIZE-1:0] POLY = 8'hB8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set0,
   input  logic            set1,
   input  logic [SIZE-1:0] key,
   input  logic            md_valid,
   input  logic [SIZE:0]   md,
   input  logic [SIZE-1:0] nk,
   output logic [SIZE-1:0] id,
   output logic            id_valid,
   output logic            err_range,
   output logic            err_seq,
   output logic [1:0]      state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ARMED = 2'b01,
      RUN   = 2'b10,
      ERR   = 2'b11
   } state_t;

   localparam logic [SIZE-1:0] ONE = 1;

   state_t          state;
   logic [SIZE-1:0] lfsr;
   logic [SIZE-1:0] cnt;
   logic [SIZE:0]   diff;
   logic [SIZE-1:0] lfsr_next;

   assign diff      = md - {1'b0, lfsr};
   assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);
   assign state_o   = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lfsr      <= ONE;
         cnt       <= '0;
         id        <= '0;
         id_valid  <= 1'b0;
         err_range <= 1'b0;
         err_seq   <= 1'b0;
      end else begin
         id_valid <= 1'b0;
         if (set0) begin
            // an all-zero seed would freeze the LFSR, so it is forced to 1
            lfsr    <= (key == '0) ? ONE : key;
            cnt     <= '0;
            err_seq <= 1'b0;
            state   <= ARMED;
         end else begin
            case (state)
               IDLE: ;
               ARMED: begin
                  if (set1)
                     state <= RUN;
               end
               RUN: begin
                  if (!set1) begin
                     state <= ARMED;
                  end else if (md_valid) begin
                     if (nk == cnt) begin
                        id        <= diff[SIZE-1:0];
                        err_range <= diff[SIZE];
                        id_valid  <= 1'b1;
                        lfsr      <= lfsr_next;
                        cnt       <= cnt + ONE;
                     end else begin
                        err_seq <= 1'b1;
                        state   <= ERR;
                     end
                  end
               end
               ERR: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gen_gamma_decoder.sv
// tb/tb_gen_gamma_decoder.sv - directed-vector bench for gen_gamma_decoder
module tb_gen_gamma_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       set0 = 1'b0;
   logic       set1 = 1'b0;
   logic [7:0] key = 8'h00;
   logic       md_valid = 1'b0;
   logic [8:0] md = 9'h000;
   logic [7:0] nk = 8'h00;
   logic [7:0] id;
   logic       id_valid;
   logic       err_range;
   logic       err_seq;
   logic [1:0] state_o;

   int nvec = 0;
   int nerr = 0;

   gen_gamma_decoder #(.SIZE(8), .POLY(8'hB8)) dut (
      .clk(clk), .rst(rst), .set0(set0), .set1(set1), .key(key),
      .md_valid(md_valid), .md(md), .nk(nk),
      .id(id), .id_valid(id_valid), .err_range(err_range),
      .err_seq(err_seq), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic word(input logic [8:0] m, input logic [7:0] n);
      md_valid = 1'b1;
      md = m;
      nk = n;
      tick;
   endtask

   function automatic logic [7:0] ref_step(input logic [7:0] g);
      logic [7:0] s;
      s = {1'b0, g[7:1]};
      if (g[0]) s = s ^ 8'hB8;
      return s;
   endfunction

   initial begin
      logic [7:0] g;
      logic [8:0] m;
      logic [8:0] d;

      // reset state
      tick;
      check("rst_id", id, 8'h00);
      check("rst_id_valid", id_valid, 1'b0);
      check("rst_err_range", err_range, 1'b0);
      check("rst_err_seq", err_seq, 1'b0);
      check("rst_state", state_o, 2'b00);
      rst = 1'b0;

      // IDLE ignores words
      set1 = 1'b1;
      word(9'h03A, 8'h00);
      check("idle_no_valid", id_valid, 1'b0);
      check("idle_state", state_o, 2'b00);
      md_valid = 1'b0;

      // key 01, arm, run
      set0 = 1'b1; key = 8'h01; tick; set0 = 1'b0;
      check("armed", state_o, 2'b01);
      tick;
      check("run", state_o, 2'b10);

      // three back-to-back good words
      word(9'h03A, 8'h00);
      check("w0_valid", id_valid, 1'b1);
      check("w0_id", id, 8'h39);
      check("w0_rng", err_range, 1'b0);
      word(9'h0C8, 8'h01);
      check("w1_valid", id_valid, 1'b1);
      check("w1_id", id, 8'h10);
      check("w1_rng", err_range, 1'b0);
      word(9'h000, 8'h02);
      check("w2_valid", id_valid, 1'b1);
      check("w2_id", id, 8'hA4);
      check("w2_rng", err_range, 1'b1);
      md_valid = 1'b0;
      tick;
      check("hold_valid", id_valid, 1'b0);
      check("hold_id", id, 8'hA4);
      check("hold_rng", err_range, 1'b1);

      // desync: cnt is 3, send nk=5
      word(9'h011, 8'h05);
      check("desync_valid", id_valid, 1'b0);
      check("desync_err", err_seq, 1'b1);
      check("desync_state", state_o, 2'b11);
      check("desync_id", id, 8'hA4);
      word(9'h011, 8'h03);
      check("err_no_valid", id_valid, 1'b0);
      check("err_stays", state_o, 2'b11);
      md_valid = 1'b0;

      // set0 recovers, counter and gamma restart
      set0 = 1'b1; key = 8'h01; tick; set0 = 1'b0;
      check("recov_err", err_seq, 1'b0);
      check("recov_state", state_o, 2'b01);
      tick;
      word(9'h03A, 8'h00);
      check("recov_w_valid", id_valid, 1'b1);
      check("recov_w_id", id, 8'h39);
      md_valid = 1'b0;

      // key 00 loads as 01; set1=0 word ignored; set0+md_valid drops word
      set0 = 1'b1; key = 8'h00; tick; set0 = 1'b0;
      tick;
      check("k0_run", state_o, 2'b10);
      set1 = 1'b0;
      word(9'h050, 8'h00);
      check("s1low_valid", id_valid, 1'b0);
      check("s1low_state", state_o, 2'b01);
      md_valid = 1'b0; set1 = 1'b1;
      tick;
      set0 = 1'b1;
      word(9'h050, 8'h00);
      set0 = 1'b0;
      check("s0drop_valid", id_valid, 1'b0);
      check("s0drop_state", state_o, 2'b01);
      md_valid = 1'b0;
      tick;
      word(9'h050, 8'h00);
      check("k0_valid", id_valid, 1'b1);
      check("k0_id", id, 8'h4F);
      check("k0_rng", err_range, 1'b0);

      // async reset mid-stream
      word(9'h0C8, 8'h01);
      check("pre_rst_id", id, 8'h10);
      rst = 1'b1;
      #1;
      check("arst_id", id, 8'h00);
      check("arst_valid", id_valid, 1'b0);
      check("arst_state", state_o, 2'b00);
      tick; tick; tick;
      check("arst_err_seq", err_seq, 1'b0);
      rst = 1'b0;
      word(9'h03A, 8'h00);
      check("post_rst_valid", id_valid, 1'b0);
      check("post_rst_state", state_o, 2'b00);
      md_valid = 1'b0;

      // 257 words from key 01, counter wraps, word 256 has nk=0
      set0 = 1'b1; key = 8'h01; tick; set0 = 1'b0;
      tick;
      g = 8'h01;
      for (int i = 0; i < 257; i++) begin
         m = 9'((i * 7 + 3) % 512);
         d = m - {1'b0, g};
         word(m, 8'(i));
         check($sformatf("wrap%0d_valid", i), id_valid, 1'b1);
         check($sformatf("wrap%0d_id", i), id, d[7:0]);
         check($sformatf("wrap%0d_rng", i), err_range, d[8]);
         g = ref_step(g);
      end
      md_valid = 1'b0;
      tick;
      check("wrap_end_valid", id_valid, 1'b0);
      check("wrap_end_seq", err_seq, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
